// File: rtl/exp_datapath.sv
// Series datapath for e^x = sum x^i/i!, stepped by external load_x/load_t/select_t strobes.
// One term per iterate strobe; done follows the counter combinationally; no backpressure.
module exp_datapath #(
  parameter int ITERATIONS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_x,
  input  logic        load_t,
  input  logic        select_t,
  input  logic [7:0]  x_in,
  output logic        done,
  output logic [17:0] result,
  output logic [15:0] term
);

  localparam logic [3:0] ITER_L = 4'(ITERATIONS);

  logic [7:0]  x_q;
  logic [15:0] t_q;
  logic [17:0] s_q;
  logic [3:0]  cnt_q;

  logic [3:0]  k;
  logic [15:0] coef;
  logic [23:0] prod1;
  logic [15:0] p1;
  logic [31:0] prod2;
  logic [15:0] tn;
  logic        at_limit;

  assign k        = cnt_q + 4'd1;
  assign at_limit = (cnt_q == ITER_L);

  // 1/k in Q1.15
  always_comb begin
    coef = 16'h0000;
    case (k)
      4'd1:    coef = 16'h8000;
      4'd2:    coef = 16'h4000;
      4'd3:    coef = 16'h2AAB;
      4'd4:    coef = 16'h2000;
      4'd5:    coef = 16'h199A;
      4'd6:    coef = 16'h1555;
      4'd7:    coef = 16'h1249;
      4'd8:    coef = 16'h1000;
      default: coef = 16'h0000;
    endcase
  end

  // T*X drops the 8 fractional bits of X; the coefficient multiply drops 15.
  assign prod1 = t_q * {16'h0000, x_q};
  assign p1    = prod1[23:8];
  assign prod2 = {16'h0000, p1} * {16'h0000, coef};
  assign tn    = prod2[30:15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= 8'h00;
    end else if (load_x) begin
      x_q <= x_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q   <= 16'h0000;
      s_q   <= 18'h00000;
      cnt_q <= 4'd0;
    end else if (load_t) begin
      if (select_t) begin
        t_q   <= 16'h8000;
        s_q   <= 18'h08000;
        cnt_q <= 4'd0;
      end else if (!at_limit) begin
        t_q   <= tn;
        s_q   <= s_q + {2'b00, tn};
        cnt_q <= k;
      end
    end
  end

  assign done   = at_limit;
  assign result = s_q;
  assign term   = t_q;

endmodule

// File: tb/tb_exp_datapath.sv
// Directed checks of the exp series datapath with ITERATIONS=8 and ITERATIONS=1 builds.
module tb_exp_datapath;

  logic        clk;
  logic        rst;
  logic        load_x;
  logic        load_t;
  logic        select_t;
  logic [7:0]  x_in;
  logic        done;
  logic [17:0] result;
  logic [15:0] term;
  logic        done1;
  logic [17:0] result1;
  logic [15:0] term1;

  int errors = 0;
  int checks = 0;

  exp_datapath #(.ITERATIONS(8)) dut (
    .clk(clk), .rst(rst), .load_x(load_x), .load_t(load_t), .select_t(select_t),
    .x_in(x_in), .done(done), .result(result), .term(term)
  );

  exp_datapath #(.ITERATIONS(1)) dut1 (
    .clk(clk), .rst(rst), .load_x(load_x), .load_t(load_t), .select_t(select_t),
    .x_in(x_in), .done(done1), .result(result1), .term(term1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive strobes for one rising edge, then release them and sample 1 time unit later.
  task automatic step(input logic lx, input logic lt, input logic st, input logic [7:0] xi);
    @(negedge clk);
    load_x   = lx;
    load_t   = lt;
    select_t = st;
    x_in     = xi;
    @(posedge clk);
    #1;
    load_x   = 1'b0;
    load_t   = 1'b0;
    select_t = 1'b0;
  endtask

  task automatic init_x(input logic [7:0] xi);
    step(1'b1, 1'b1, 1'b1, xi);
  endtask

  task automatic iterate();
    step(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_x = 1'b0; load_t = 1'b0; select_t = 1'b0; x_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({done, result, term} !== {1'b0, 18'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_state: done=%0b result=%h term=%h want 0/0/0", done, result, term);
    end
    rst = 1'b0;
  endtask

  task automatic test_half();
    init_x(8'h80);
    checks++;
    if (term !== 16'h8000 || result !== 18'h08000) begin
      errors++;
      $display("FAIL half_init: term=%h result=%h want 8000/08000", term, result);
    end
    iterate();
    checks++;
    if (term !== 16'h4000 || result !== 18'h0C000) begin
      errors++;
      $display("FAIL half_it1: term=%h result=%h want 4000/0c000", term, result);
    end
    iterate();
    checks++;
    if (term !== 16'h1000 || result !== 18'h0D000 || done !== 1'b0) begin
      errors++;
      $display("FAIL half_it2: term=%h result=%h done=%0b want 1000/0d000/0", term, result, done);
    end
  endtask

  task automatic test_zero();
    init_x(8'h00);
    for (int i = 1; i <= 8; i++) begin
      iterate();
      checks++;
      if (done !== (i == 8)) begin
        errors++;
        $display("FAIL zero_done_%0d: done=%0b want %0b", i, done, (i == 8));
      end
    end
    checks++;
    if (term !== 16'h0000 || result !== 18'h08000) begin
      errors++;
      $display("FAIL zero_final: term=%h result=%h want 0000/08000", term, result);
    end
  endtask

  task automatic test_near_one();
    // Truncated series for x=255/256 sums to 88721 (~2.7075).
    init_x(8'hFF);
    repeat (8) iterate();
    checks++;
    if (done !== 1'b1 || result !== 18'h15A91 || term !== 16'h0000) begin
      errors++;
      $display("FAIL ff_final: done=%0b result=%h term=%h want 1/15a91/0000", done, result, term);
    end
    checks++;
    if (result < 18'h15A00 || result > 18'h15C00) begin
      errors++;
      $display("FAIL ff_range: result=%h want about 2.71", result);
    end
    iterate();
    iterate();
    checks++;
    if (done !== 1'b1 || result !== 18'h15A91 || term !== 16'h0000) begin
      errors++;
      $display("FAIL ff_saturate: done=%0b result=%h term=%h want 1/15a91/0000", done, result, term);
    end
  endtask

  task automatic test_x_swap();
    init_x(8'h80);
    step(1'b1, 1'b1, 1'b0, 8'h40);
    checks++;
    if (term !== 16'h4000) begin
      errors++;
      $display("FAIL swap_old_x: term=%h want 4000", term);
    end
    iterate();
    checks++;
    if (term !== 16'h0800 || result !== 18'h0C800) begin
      errors++;
      $display("FAIL swap_new_x: term=%h result=%h want 0800/0c800", term, result);
    end
  endtask

  task automatic test_async_reset();
    init_x(8'h80);
    repeat (3) iterate();
    checks++;
    if (term !== 16'h02AA || result !== 18'h0D2AA) begin
      errors++;
      $display("FAIL pre_reset: term=%h result=%h want 02aa/0d2aa", term, result);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({done, result, term} !== {1'b0, 18'h0, 16'h0}) begin
      errors++;
      $display("FAIL async_reset: done=%0b result=%h term=%h want 0/0/0", done, result, term);
    end
    step(1'b1, 1'b1, 1'b1, 8'h80);
    checks++;
    if ({done, result, term} !== {1'b0, 18'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_ignores_load: done=%0b result=%h term=%h want 0/0/0", done, result, term);
    end
    @(negedge clk);
    rst = 1'b0;
    test_half();
  endtask

  task automatic test_iter1();
    init_x(8'h80);
    checks++;
    if (done1 !== 1'b0 || result1 !== 18'h08000) begin
      errors++;
      $display("FAIL it1_init: done=%0b result=%h want 0/08000", done1, result1);
    end
    iterate();
    checks++;
    if (done1 !== 1'b1 || result1 !== 18'h0C000) begin
      errors++;
      $display("FAIL it1_done: done=%0b result=%h want 1/0c000", done1, result1);
    end
    iterate();
    checks++;
    if (done1 !== 1'b1 || result1 !== 18'h0C000 || term1 !== 16'h4000) begin
      errors++;
      $display("FAIL it1_hold: done=%0b result=%h term=%h want 1/0c000/4000", done1, result1, term1);
    end
  endtask

  initial begin
    test_reset();
    test_half();
    test_zero();
    test_near_one();
    test_x_swap();
    test_async_reset();
    test_iter1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
